// File: rtl/my9262_pkg.sv
// Shared constants and FSM state type for the MY9262 grayscale feeder.
//   CH_NUM  : channels per frame
//   GRAY_W  : grayscale word width
//   DIM_W   : global dimming factor width
//   state_t : frame sequencer states
package my9262_pkg;

   localparam int CH_NUM = 16;
   localparam int GRAY_W = 16;
   localparam int DIM_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_DONE
   } state_t;

endpackage

// File: rtl/my9262_dim_mul.sv
// Combinational grayscale dimmer: scaled_o = (word_i * (dim_i + 1)) >> DIM_W.
// The caller registers the result.
//   word_i   : grayscale word to scale
//   dim_i    : dimming factor (all ones passes the word unchanged)
//   scaled_o : low GRAY_W bits of the shifted product
module my9262_dim_mul #(
   parameter int GRAY_W = my9262_pkg::GRAY_W,
   parameter int DIM_W  = my9262_pkg::DIM_W
) (
   input  logic [GRAY_W-1:0] word_i,
   input  logic [DIM_W-1:0]  dim_i,
   output logic [GRAY_W-1:0] scaled_o
);

   localparam int PROD_W = GRAY_W + DIM_W + 1;

   logic [DIM_W:0]    factor;
   logic [PROD_W-1:0] prod;
   logic              unused_prod_bits;

   always_comb begin
      // dim+1 needs one extra bit so that the all-ones factor scales by exactly 1.0
      factor   = {1'b0, dim_i} + (DIM_W + 1)'(1);
      prod     = PROD_W'(word_i) * PROD_W'(factor);
      scaled_o = prod[DIM_W +: GRAY_W];
   end

   // Fraction bits and the top guard bit are intentionally discarded.
   assign unused_prod_bits = ^{prod[PROD_W-1], prod[DIM_W-1:0]};

endmodule

// File: rtl/my9262_gray_feeder.sv
// Frame source for the MY9262 serializer. The host writes a shadow bank; a
// commit (or a periodic refresh tick) starts a frame that streams the active
// bank from channel CH_NUM-1 down to 0, dimmed by a factor sampled at frame
// start, over a valid/ready handshake.
//   CLK_60M, RST_N         : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  : shadow bank write port
//   commit                 : request to send the shadow bank as the next frame
//   dim                    : global dim factor, captured at frame start
//   refresh_en             : enable periodic resend of the active bank
//   gray_data/valid/last   : word stream to the serializer (last = channel 0)
//   gray_ready             : serializer accepts the current word
//   frame_done             : serializer has latched the frame
//   busy                   : sequencer is not idle
module my9262_gray_feeder #(
   parameter int CH_NUM      = my9262_pkg::CH_NUM,
   parameter int GRAY_W      = my9262_pkg::GRAY_W,
   parameter int DIM_W       = my9262_pkg::DIM_W,
   parameter int REFRESH_CYC = 60000
) (
   input  logic                      CLK_60M,
   input  logic                      RST_N,
   input  logic                      wr_en,
   input  logic [$clog2(CH_NUM)-1:0] wr_addr,
   input  logic [GRAY_W-1:0]         wr_data,
   input  logic                      commit,
   input  logic [DIM_W-1:0]          dim,
   input  logic                      refresh_en,
   output logic [GRAY_W-1:0]         gray_data,
   output logic                      gray_valid,
   input  logic                      gray_ready,
   output logic                      gray_last,
   input  logic                      frame_done,
   output logic                      busy
);

   import my9262_pkg::*;

   localparam int IDX_W = $clog2(CH_NUM);
   localparam int CNT_W = $clog2(REFRESH_CYC);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d, idx_dec;
   logic [DIM_W-1:0]    dim_q, dim_d;
   logic [GRAY_W-1:0]   gray_data_q, gray_data_d;
   logic                gray_valid_q, gray_valid_d;
   logic                gray_last_q, gray_last_d;
   logic                commit_pend_q, commit_pend_d;
   logic                refresh_pend_q, refresh_pend_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cnt_wrap, refresh_tick;
   logic [GRAY_W-1:0]   shadow_q [CH_NUM];
   logic [GRAY_W-1:0]   active_q [CH_NUM];
   logic [GRAY_W-1:0]   mul_word, mul_out;
   logic [DIM_W-1:0]    mul_dim;

   my9262_dim_mul #(
      .GRAY_W (GRAY_W),
      .DIM_W  (DIM_W)
   ) u_dim_mul (
      .word_i   (mul_word),
      .dim_i    (mul_dim),
      .scaled_o (mul_out)
   );

   // Free-running refresh counter; it wraps whether or not refresh is enabled.
   assign cnt_wrap     = (cnt_q == CNT_W'(REFRESH_CYC - 1));
   assign refresh_tick = cnt_wrap & refresh_en;
   assign cnt_d        = cnt_wrap ? '0 : cnt_q + CNT_W'(1);

   // A request arriving during LOAD survives the clear and is served next frame.
   assign commit_pend_d  = commit | (commit_pend_q & (state_q != LOAD));
   assign refresh_pend_d = refresh_tick | (refresh_pend_q & (state_q != LOAD));

   assign idx_dec = idx_q - IDX_W'(1);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dim_d        = dim_q;
      gray_data_d  = gray_data_q;
      gray_valid_d = gray_valid_q;
      gray_last_d  = gray_last_q;
      mul_word     = active_q[idx_dec];
      mul_dim      = dim_q;

      case (state_q)
         IDLE: begin
            // Raw requests are looked at too so LOAD follows a commit by one cycle.
            if (commit_pend_q | refresh_pend_q | commit | refresh_tick) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            // The first word is scaled from the values being loaded this cycle,
            // so it is ready the moment valid rises.
            mul_word     = commit_pend_q ? shadow_q[CH_NUM-1] : active_q[CH_NUM-1];
            mul_dim      = dim;
            dim_d        = dim;
            idx_d        = IDX_W'(CH_NUM - 1);
            gray_data_d  = mul_out;
            gray_valid_d = 1'b1;
            gray_last_d  = (CH_NUM == 1);
            state_d      = SEND;
         end
         SEND: begin
            if (gray_valid_q && gray_ready) begin
               if (idx_q == '0) begin
                  gray_valid_d = 1'b0;
                  gray_last_d  = 1'b0;
                  state_d      = WAIT_DONE;
               end else begin
                  idx_d       = idx_dec;
                  gray_data_d = mul_out;
                  gray_last_d = (idx_q == IDX_W'(1));
               end
            end
         end
         WAIT_DONE: begin
            if (frame_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_60M or negedge RST_N) begin
      if (!RST_N) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         dim_q          <= '0;
         gray_data_q    <= '0;
         gray_valid_q   <= 1'b0;
         gray_last_q    <= 1'b0;
         commit_pend_q  <= 1'b0;
         refresh_pend_q <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         dim_q          <= dim_d;
         gray_data_q    <= gray_data_d;
         gray_valid_q   <= gray_valid_d;
         gray_last_q    <= gray_last_d;
         commit_pend_q  <= commit_pend_d;
         refresh_pend_q <= refresh_pend_d;
         cnt_q          <= cnt_d;
      end
   end

   always_ff @(posedge CLK_60M or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < CH_NUM; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            shadow_q[wr_addr] <= wr_data;
         end
         // Refresh-only frames resend the active bank untouched.
         if (state_q == LOAD && commit_pend_q) begin
            for (int i = 0; i < CH_NUM; i++) begin
               active_q[i] <= shadow_q[i];
            end
         end
      end
   end

   assign gray_data  = gray_data_q;
   assign gray_valid = gray_valid_q;
   assign gray_last  = gray_last_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: doc/my9262_gray_feeder.md
# my9262_gray_feeder

Upstream frame source for the MY9262 serializer. It holds a host-writable shadow bank of 16 channel grayscale words and a separate active bank. It streams the active bank, one 16-bit word per handshake, to the serializer, which shifts the words out on `my9262_Di` and pulses `my9262_Lat`. A new frame starts on a host commit or on a periodic refresh tick; a global dimming factor is applied per word on the way out.

## Interface
- `CH_NUM`, 16: channels per frame.
- `GRAY_W`, 16: grayscale word width.
- `DIM_W`, 8: dimming factor width.
- `REFRESH_CYC`, 60000: refresh period in `CLK_60M` cycles (1 kHz).

- `CLK_60M` in 1: system clock from the PLL.
- `RST_N` in 1: asynchronous, active-low reset.
- `wr_en` in 1: shadow bank write strobe.
- `wr_addr` in 4: channel index to write.
- `wr_data` in `GRAY_W`: grayscale value.
- `commit` in 1: one-cycle pulse requesting that shadow be sent as the next frame.
- `dim` in `DIM_W`: global dim factor, sampled at frame start.
- `refresh_en` in 1: enables periodic resend.
- `gray_data` out `GRAY_W`: scaled word to the serializer.
- `gray_valid` out 1: `gray_data` is valid.
- `gray_ready` in 1: serializer accepts the word.
- `gray_last` out 1: marks channel 0, the final word of the frame.
- `frame_done` in 1: serializer pulse after `my9262_Lat`.
- `busy` out 1: high in every state except IDLE.

## Operation
- Writes go to the shadow bank only and are always accepted. The active bank is never written directly.
- `commit` sets `commit_pend`. If the refresh counter reaches `REFRESH_CYC-1` while `refresh_en`=1, `refresh_pend` is set. The counter wraps to 0 unconditionally.
- **IDLE**: if either pend flag is set, go to LOAD.
- **LOAD** (1 cycle):
  - If `commit_pend` is set, copy all CH_NUM shadow words into the active bank in parallel.
  - Clear both pend flags.
  - Capture `dim` into `dim_q`.
  - Set `idx` = CH_NUM-1.
  - Go to SEND.
- **SEND**:
  - Register `gray_data` = (active[idx] × (dim_q+1)) >> DIM_W. The product is GRAY_W+DIM_W+1 bits wide; take the low GRAY_W bits after the shift. `dim_q`=255 therefore passes the value unchanged, and `dim_q`=0 gives value>>8.
  - `gray_last` = (idx==0).
  - On `gray_valid` & `gray_ready`: if idx==0, drop `gray_valid` and go to WAIT_DONE; otherwise decrement idx and load the next word.
- **WAIT_DONE**: hold until `frame_done`, then go to IDLE.
- Channel order is CH_NUM-1 down to 0.
- While `gray_valid` is high and `gray_ready` is low, `gray_data` and `gray_last` hold stable.
- A `commit` arriving in SEND or WAIT_DONE stays pending and is served at the next frame start. Multiple commits merge into one.
- A refresh tick arriving during a frame likewise stays pending; it causes at most one resend.
- `wr_en` and `commit` in the same cycle: the write is included in the committed frame.
- `frame_done` outside WAIT_DONE is ignored.
- Reset, including mid-frame:
  - Both banks, `dim_q`, `idx`, the refresh counter and both pend flags clear to 0; state goes to IDLE.
  - Outputs reset to `gray_valid`=0, `gray_last`=0, `gray_data`=0, `busy`=0.
  - The serializer is reset by the same `RST_N`, so no partial frame resumes.

## Timing
- A `commit` in cycle N gives LOAD in N+1.
- `gray_valid` first goes high in N+2, with `gray_data` already scaled.
- With `gray_ready` tied high, one word is accepted per cycle: 16 words occupy N+2..N+17, and `gray_last` is high in N+17.
- `busy` rises in N+1 and falls in the cycle after `frame_done`.
- The multiplier is a single registered stage; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `my9262_pkg`:
  - `CH_NUM` and `GRAY_W` constants.
  - State enum {IDLE, LOAD, SEND, WAIT_DONE}.
- Sub-module `my9262_dim_mul`: combinational GRAY_W × DIM_W scale with shift. It is registered by the parent.
- The refresh counter and the FSM stay inline.

## Test plan
- Write ch15=0xFFFF, ch0=0x1234, others 0; `dim`=255; commit; `gray_ready`=1.
  - Expected: words 0xFFFF, 0×14, 0x1234 in cycles N+2..N+17.
  - `gray_last` is high only with 0x1234.
- `dim`=127 and ch15=0x8000, then commit.
  - Expected: first word 0x4000.
  - Changing `dim` mid-frame does not alter the rest of the frame.
- Hold `gray_ready`=0 for 5 cycles at word 3.
  - Expected: `gray_data` is held stable, and no word is skipped or duplicated.
- Commit during SEND with a changed ch7, issued twice.
  - Expected: the current frame is unchanged; after `frame_done` exactly one new frame carries the new ch7.
- `refresh_en`=1 and `REFRESH_CYC`=100 in the bench, with no commits.
  - Expected: an identical frame every 100 cycles, and the active bank is not recopied.
- Assert `RST_N`=0 at word 8.
  - Expected: `gray_valid`=0 and `busy`=0 immediately.
  - After release, no frame starts until a commit arrives, and that frame sends zeros for all unwritten channels.
